memory_load_resp: RTL
=====================

MEMORY_LOAD_RESP -- requirements
Module: memory_load_resp

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have port MemoryArgs, input, memory_args_t: load descriptor (valid, write, msize, addr); sampled only when start=1 in IDLE.
REQ-004 SHALL have port start, input, 1 bit: issue a load; ignored when not IDLE or when MemoryArgs.valid=0 or MemoryArgs.write=1.
REQ-005 SHALL have port ld_unsigned, input, 1 bit: 1 means zero-extend, 0 means sign-extend; captured with start.
REQ-006 SHALL have port flush, input, 1 bit: abort the current load.
REQ-007 SHALL have ports dreq_valid (output, 1), dreq_addr (output, 32, word-aligned) and dreq_size (output, msize_t): bus request.
REQ-008 SHALL have ports addr_ok (input, 1) and data_ok (input, 1): bus accept and response strobes.
REQ-009 SHALL have port resp_data, input, word_t: bus read word, valid only when data_ok=1.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1), rdata (output, word_t) and exc_adel (output, 1): result handshake.
REQ-011 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-012 SHALL implement the five states IDLE, REQ, WAIT, HOLD and DRAIN.
REQ-013 In IDLE with an accepted start, SHALL capture msize, addr[1:0] and ld_unsigned. It SHALL go to HOLD with exc_adel=1 on a misaligned access (MSIZE2 with addr[0]=1, or MSIZE4 with addr[1:0]!=0). Otherwise it SHALL go to REQ.
REQ-014 In REQ, SHALL hold dreq_valid=1 and present dreq_addr={addr[31:2],2'b00} and the captured dreq_size. It SHALL go to WAIT on addr_ok.
REQ-015 In WAIT, on data_ok SHALL latch the aligned and extended result into rdata and go to HOLD.
REQ-016 SHALL extract the result as follows: MSIZE1 takes byte addr[1:0] of resp_data; MSIZE2 takes halfword addr[1] (0 is low, 1 is high); MSIZE4 takes the whole word. Sub-word results SHALL be sign- or zero-extended to 32 bits per ld_unsigned.
REQ-017 In HOLD, SHALL hold out_valid=1 and keep rdata and exc_adel stable. It SHALL return to IDLE on out_ready=1. exc_adel=1 SHALL force rdata=0.
REQ-018 SHALL make the result available with minimum latency: start to REQ in 1 cycle; a combinational addr_ok in REQ moves to WAIT; data_ok in WAIT gives out_valid on the next cycle.
REQ-019 On flush in REQ with addr_ok=0, SHALL go to IDLE and drop dreq_valid; the bus permits withdrawal.
REQ-020 On flush in REQ with addr_ok=1, or in WAIT with data_ok=0, SHALL go to DRAIN.
REQ-021 On flush in WAIT with data_ok=1, SHALL discard the data and go to IDLE.
REQ-022 On flush in HOLD, SHALL go to IDLE with no out_valid beat after the flush cycle.
REQ-023 In DRAIN, SHALL wait for data_ok, discard resp_data, then go to IDLE. out_valid SHALL never assert for a drained load.
REQ-024 SHALL ignore start while busy=1, and SHALL not accept a new start in the same cycle it leaves HOLD.
REQ-025 SHALL ignore data_ok in IDLE and REQ; the bus guarantees none is outstanding in these states.

Reset
REQ-026 While resetn=0, the state SHALL be IDLE and dreq_valid, out_valid, exc_adel, busy, rdata and dreq_addr SHALL all be 0.
REQ-027 Reset mid-load SHALL abandon the load without a DRAIN; the bus is reset together with this block.

Structure
REQ-028 The state enum typedef SHALL live in the shared mycpu package, next to memory_args_t, msize_t and word_t.
REQ-029 The byte/halfword extraction and extension SHALL be one combinational sub-module, memory_load_extract (inputs resp_data, msize, offset, ld_unsigned; output word_t).

Verification
REQ-030 Scenario: lb at addr 0x1003, signed, with resp_data=0x80FF_1234 SHALL give rdata=0xFFFF_FF80 and exc_adel=0.
REQ-031 Scenario: lhu at addr 0x1002 with resp_data=0x8001_7FFF SHALL give rdata=0x0000_8001; lh at offset 0 SHALL give 0x0000_7FFF.
REQ-032 Scenario: lw at 0x1002 SHALL give no dreq_valid, out_valid one cycle after start, exc_adel=1 and rdata=0.
REQ-033 Scenario: flush in WAIT with data_ok two cycles later SHALL produce DRAIN, no out_valid, and busy falling the cycle after data_ok.
REQ-034 Scenario: out_ready held 0 for 5 cycles in HOLD SHALL keep rdata stable, and start pulses meanwhile SHALL be ignored.
REQ-035 Scenario: resetn low in WAIT SHALL drive all outputs to 0 immediately, asynchronously.

Source files
------------

// File: rtl/mycpu_pkg.sv
// Shared CPU types used by the load-response path.
// Contents: word_t, msize_t, memory_args_t (load/store descriptor), load_state_t
// (load-response FSM states), and is_misaligned() for the address-error check.
package mycpu_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic   valid;
        logic   write;
        msize_t msize;
        word_t  addr;
    } memory_args_t;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } load_state_t;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input msize_t msize, input logic [1:0] offset);
        case (msize)
            MSIZE2:  return offset[0];
            MSIZE4:  return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/memory_load_resp_if.sv
// Data-bus request/response bundle between a load unit and memory.
// Signals: dreq_valid/dreq_addr/dreq_size (request, from master),
//          addr_ok (request accepted), data_ok + resp_data (read response).
// Modports: master = load unit side, slave = memory side.
interface memory_load_resp_if;
    import mycpu_pkg::*;

    logic   dreq_valid;
    word_t  dreq_addr;
    msize_t dreq_size;
    logic   addr_ok;
    logic   data_ok;
    word_t  resp_data;

    modport master (
        output dreq_valid, dreq_addr, dreq_size,
        input  addr_ok, data_ok, resp_data
    );

    modport slave (
        input  dreq_valid, dreq_addr, dreq_size,
        output addr_ok, data_ok, resp_data
    );

endinterface

// File: rtl/memory_load_extract.sv
// Selects the addressed byte/halfword out of a bus read word and extends it.
// Ports: resp_data (bus word), msize (access size), offset (addr[1:0]),
//        ld_unsigned (1 = zero-extend, 0 = sign-extend), data (32-bit result).
module memory_load_extract
    import mycpu_pkg::*;
(
    input  word_t      resp_data,
    input  msize_t     msize,
    input  logic [1:0] offset,
    input  logic       ld_unsigned,
    output word_t      data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset)
            2'd0:    byte_sel = resp_data[7:0];
            2'd1:    byte_sel = resp_data[15:8];
            2'd2:    byte_sel = resp_data[23:16];
            default: byte_sel = resp_data[31:24];
        endcase

        half_sel = offset[1] ? resp_data[31:16] : resp_data[15:0];

        case (msize)
            MSIZE1:  data = {{24{~ld_unsigned & byte_sel[7]}}, byte_sel};
            MSIZE2:  data = {{16{~ld_unsigned & half_sel[15]}}, half_sel};
            default: data = resp_data;
        endcase
    end

endmodule

// File: rtl/memory_load_resp.sv
// Load-response engine: issues one word-aligned bus read per accepted load,
// extracts/extends the addressed bytes, and holds the result until consumed.
// Misaligned accesses skip the bus and report exc_adel with rdata=0.
// Flush withdraws an unaccepted request, or drains an accepted one so its
// data never reaches the result port.
// Ports: clk, resetn (async, active-low); MemoryArgs/start/ld_unsigned (issue);
//        flush; bus (request/response, master side);
//        out_valid/out_ready/rdata/exc_adel (result); busy (not IDLE).
module memory_load_resp
    import mycpu_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    input  memory_args_t               MemoryArgs,
    input  logic                       start,
    input  logic                       ld_unsigned,
    input  logic                       flush,
    memory_load_resp_if.master         bus,
    output logic                       out_valid,
    input  logic                       out_ready,
    output word_t                      rdata,
    output logic                       exc_adel,
    output logic                       busy
);

    load_state_t state, state_nx;

    word_t  addr_q;
    msize_t msize_q;
    logic   uns_q;
    logic   exc_q;
    word_t  rdata_q;
    word_t  ext_data;

    logic accept;
    logic misaligned;

    assign accept     = (state == IDLE) && start && MemoryArgs.valid && !MemoryArgs.write;
    assign misaligned = is_misaligned(MemoryArgs.msize, MemoryArgs.addr[1:0]);

    memory_load_extract u_extract (
        .resp_data   (bus.resp_data),
        .msize       (msize_q),
        .offset      (addr_q[1:0]),
        .ld_unsigned (uns_q),
        .data        (ext_data)
    );

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept) state_nx = misaligned ? HOLD : REQ;
            end
            REQ: begin
                // Without addr_ok the request can simply be withdrawn; once
                // accepted, a response is owed and must be drained.
                if (flush)             state_nx = bus.addr_ok ? DRAIN : IDLE;
                else if (bus.addr_ok)  state_nx = WAIT;
            end
            WAIT: begin
                if (flush)             state_nx = bus.data_ok ? IDLE : DRAIN;
                else if (bus.data_ok)  state_nx = HOLD;
            end
            HOLD: begin
                if (flush || out_ready) state_nx = IDLE;
            end
            DRAIN: begin
                if (bus.data_ok) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        bus.dreq_valid = (state == REQ);
        out_valid      = (state == HOLD);
        busy           = (state != IDLE);
        exc_adel       = (state == HOLD) && exc_q;
    end

    assign bus.dreq_addr = {addr_q[31:2], 2'b00};
    assign bus.dreq_size = msize_q;
    assign rdata         = rdata_q;

    // Descriptor capture and result latch. rdata is cleared on issue so an
    // address-error result reads back as zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q  <= '0;
            msize_q <= MSIZE1;
            uns_q   <= 1'b0;
            exc_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= MemoryArgs.addr;
                msize_q <= MemoryArgs.msize;
                uns_q   <= ld_unsigned;
                exc_q   <= misaligned;
                rdata_q <= '0;
            end else if ((state == WAIT) && bus.data_ok && !flush) begin
                rdata_q <= ext_data;
            end
        end
    end

endmodule
